nonce_scheduler: RTL and testbench

Sequencer that drives the SHA-256 `compression` core for double-SHA-256 Bitcoin header search. It latches an 80-byte header, target and nonce range, then for each nonce:
- builds and expands the message schedules,
- runs the core twice (two-block first hash, one-block second hash),
- compares the result against the target.

It sits between the job/host interface and the `compression` core. It stops on the first winning nonce, on range exhaustion, or on abort.

---
 rtl/sha256_pkg.sv | 44 ++++
 rtl/msg_expand.sv | 42 ++++
 rtl/nonce_scheduler.sv | 163 ++++++++++++++++
 tb/tb_nonce_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 round constants and IV shared with the compression core, plus the
// padding constants, scheduler state encoding and schedule helper functions.
package sha256_pkg;

  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
    32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
    32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
    32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
    32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
    32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] PadWord = 32'h8000_0000;
  localparam logic [63:0] LenHdr  = 64'h280;  // 640-bit header message
  localparam logic [63:0] LenDig  = 64'h100;  // 256-bit digest message

  typedef enum logic [2:0] {
    StIdle, StExpH, StExpN, StRun1, StExpD, StRun2, StCheck, StDone
  } state_e;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/msg_expand.sv
// SHA-256 message schedule expander: one new word per cycle for 48 cycles.
// The low 16 words of the shift register form the sliding window.
module msg_expand
  import sha256_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [511:0]  words_in,
  output logic          done,
  output logic [2047:0] sched_out
);

  logic [2047:0] sched_q, src;
  logic [5:0]    cnt_q, cnt;
  logic          busy_q, run;
  logic [31:0]   w_new;

  // load computes W16 straight from words_in so a run takes exactly 48 cycles;
  // sched_out is the complete schedule during the cycle done is high.
  always_comb begin
    src       = load ? {1536'b0, words_in} : sched_q;
    cnt       = load ? 6'd0 : cnt_q;
    run       = load | busy_q;
    done      = run && (cnt == 6'd47);
    w_new     = sig1(src[63:32]) + src[223:192] + sig0(src[479:448]) + src[511:480];
    sched_out = {src[2015:0], w_new};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (run) begin
      sched_q <= sched_out;
      cnt_q   <= cnt + 6'd1;
      busy_q  <= (cnt != 6'd47);
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Double-SHA-256 header search sequencer: builds schedules, drives the
// compression core twice per nonce and compares the result with the target.
module nonce_scheduler
  import sha256_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [639:0]  header,
  input  logic [255:0]  target,
  input  logic [31:0]   nonce_start,
  input  logic [31:0]   nonce_end,
  output logic          core_start,
  output logic          core_hash_count,
  output logic [2047:0] core_first_block,
  output logic [2047:0] core_second_block,
  input  logic          core_done,
  input  logic [255:0]  core_hash,
  output logic          busy,
  output logic          found,
  output logic          exhausted,
  output logic [31:0]   found_nonce
);

  state_e        state_q;
  logic          first_q, core_start_q, hash_cnt_q, found_q, exh_q;
  logic [607:0]  hdr_q;
  logic [255:0]  target_q, dig_q, hash_q;
  logic [31:0]   nonce_q, end_q, fnonce_q;
  logic [2047:0] sa_q, sb_q, sc_q;
  logic [511:0]  exp_words;
  logic          exp_done;
  logic [2047:0] exp_sched;
  logic          unused_nonce_field;

  assign unused_nonce_field = ^header[31:0];

  always_comb begin
    case (state_q)
      StExpH:  exp_words = hdr_q[607:96];
      StExpD:  exp_words = {dig_q, PadWord, 160'b0, LenDig};
      default: exp_words = {hdr_q[95:0], bswap32(nonce_q), PadWord, 288'b0, LenHdr};
    endcase
  end

  msg_expand u_expand (
    .clk       (clk),
    .rst       (rst),
    .load      (first_q),
    .words_in  (exp_words),
    .done      (exp_done),
    .sched_out (exp_sched)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      first_q      <= 1'b0;
      core_start_q <= 1'b0;
      hash_cnt_q   <= 1'b0;
      found_q      <= 1'b0;
      exh_q        <= 1'b0;
      fnonce_q     <= '0;
      hdr_q        <= '0;
      target_q     <= '0;
      dig_q        <= '0;
      hash_q       <= '0;
      nonce_q      <= '0;
      end_q        <= '0;
      sa_q         <= '0;
      sb_q         <= '0;
      sc_q         <= '0;
    end else if (abort) begin
      state_q      <= StIdle;
      first_q      <= 1'b0;
      core_start_q <= 1'b0;
      hash_cnt_q   <= 1'b0;
      found_q      <= 1'b0;
      exh_q        <= 1'b0;
      fnonce_q     <= '0;
    end else begin
      core_start_q <= 1'b0;
      first_q      <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            hdr_q    <= header[639:32];
            target_q <= target;
            nonce_q  <= nonce_start;
            end_q    <= nonce_end;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            fnonce_q <= '0;
            first_q  <= 1'b1;
            state_q  <= StExpH;
          end
        end
        StExpH: begin
          if (exp_done) begin
            sa_q    <= exp_sched;
            first_q <= 1'b1;
            state_q <= StExpN;
          end
        end
        StExpN: begin
          if (exp_done) begin
            sb_q         <= exp_sched;
            core_start_q <= 1'b1;
            hash_cnt_q   <= 1'b0;
            state_q      <= StRun1;
          end
        end
        StRun1: begin
          if (core_done) begin
            dig_q   <= core_hash;
            first_q <= 1'b1;
            state_q <= StExpD;
          end
        end
        StExpD: begin
          if (exp_done) begin
            sc_q         <= exp_sched;
            core_start_q <= 1'b1;
            hash_cnt_q   <= 1'b1;
            state_q      <= StRun2;
          end
        end
        StRun2: begin
          if (core_done) begin
            hash_q  <= core_hash;
            state_q <= StCheck;
          end
        end
        StCheck: begin
          if (hash_q <= target_q) begin
            found_q  <= 1'b1;
            fnonce_q <= nonce_q;
            state_q  <= StDone;
          end else if (nonce_q == end_q) begin
            exh_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            nonce_q <= nonce_q + 32'd1;
            first_q <= 1'b1;
            state_q <= StExpN;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign core_start        = core_start_q;
  assign core_hash_count   = hash_cnt_q;
  assign core_first_block  = hash_cnt_q ? sc_q : sa_q;
  assign core_second_block = sb_q;
  assign busy              = (state_q != StIdle) && (state_q != StDone);
  assign found             = found_q;
  assign exhausted         = exh_q;
  assign found_nonce       = fnonce_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: behavioural SHA-256 core, nonce and result
// scoreboards, and directed jobs over the genesis header.
module tb_nonce_scheduler;
  import sha256_pkg::*;

  localparam int unsigned CoreLat   = 4;
  localparam int          JobBudget = 5000;
  localparam logic [639:0] GenHdr = {
    32'h01000000, 256'h0,
    256'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa4b1e5e4a,
    32'h29ab5f49, 32'hffff001d, 32'hdeadbeef
  };
  localparam logic [255:0] GenTgt  = {32'h0, 32'hffff0000, 192'h0};
  localparam logic [255:0] GenHash =
    256'h000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [639:0]  header;
  logic [255:0]  target;
  logic [31:0]   nonce_start, nonce_end;
  logic          core_start, core_hash_count;
  logic [2047:0] core_first_block, core_second_block;
  logic          core_done = 1'b0;
  logic [255:0]  core_hash = '0;
  logic          busy, found, exhausted;
  logic [31:0]   found_nonce;
  logic          x_load, x_done;
  logic [511:0]  x_words;
  logic [2047:0] x_sched;

  always #5 clk = ~clk;

  nonce_scheduler u_dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .header            (header),
    .target            (target),
    .nonce_start       (nonce_start),
    .nonce_end         (nonce_end),
    .core_start        (core_start),
    .core_hash_count   (core_hash_count),
    .core_first_block  (core_first_block),
    .core_second_block (core_second_block),
    .core_done         (core_done),
    .core_hash         (core_hash),
    .busy              (busy),
    .found             (found),
    .exhausted         (exhausted),
    .found_nonce       (found_nonce)
  );

  msg_expand u_exp (
    .clk       (clk),
    .rst       (rst),
    .load      (x_load),
    .words_in  (x_words),
    .done      (x_done),
    .sched_out (x_sched)
  );

  typedef struct packed {
    logic        found;
    logic        exh;
    logic [31:0] nonce;
  } res_t;

  int           n_tests = 0;
  int           n_fail  = 0;
  int           run2_cnt = 0;
  int           last_cycles = 0;
  res_t         res_q[$];
  logic [31:0]  nonce_q[$];
  logic [255:0] last_hash = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] swap_bytes(input logic [31:0] n);
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
  endfunction

  function automatic logic [255:0] rev_bytes(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [2047:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i]
           + w[2047-32*i -: 32];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
  endfunction

  // Compression core model: rounds only, schedules come from the DUT.
  logic         m_cnt;
  logic [255:0] m_h;
  logic [31:0]  m_exp;
  always begin
    @(negedge clk);
    if (core_start === 1'b1) begin
      m_cnt = core_hash_count;
      m_h   = compress(IV, core_first_block);
      if (m_cnt == 1'b0) begin
        check("nonce_pending", nonce_q.size() > 0, 1);
        if (nonce_q.size() > 0) begin
          m_exp = nonce_q.pop_front();
          check("nonce_order", core_second_block[1951:1920], swap_bytes(m_exp));
        end
        m_h = compress(m_h, core_second_block);
      end else begin
        m_h = rev_bytes(m_h);
        run2_cnt++;
        last_hash = m_h;
      end
      repeat (CoreLat - 1) @(negedge clk);
      check("hash_count_stable", core_hash_count, m_cnt);
      core_hash = m_h;
      core_done = 1'b1;
      @(negedge clk);
      core_done = 1'b0;
    end
  end

  task automatic run_job(input string tag, input logic [255:0] tgt, input logic [31:0] ns,
                         input logic [31:0] ne, input logic ef, input logic ee,
                         input logic [31:0] en, input int passes, input bit poke);
    res_t r;
    int   c;
    res_q.push_back('{found: ef, exh: ee, nonce: en});
    run2_cnt = 0;
    @(negedge clk);
    header = GenHdr; target = tgt; nonce_start = ns; nonce_end = ne; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (busy === 1'b1 && c < JobBudget) begin
      // A start pulse while busy must not disturb the job.
      if (poke && c == 100) begin
        start = 1'b1; nonce_start = 32'h0;
      end else begin
        start = 1'b0; nonce_start = ns;
      end
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    last_cycles = c;
    check({tag, "_finished"}, busy, 0);
    r = res_q.pop_front();
    check({tag, "_found"}, found, r.found);
    check({tag, "_exhausted"}, exhausted, r.exh);
    if (r.found) check({tag, "_found_nonce"}, found_nonce, r.nonce);
    check({tag, "_run2_passes"}, run2_cnt, passes);
    check({tag, "_nonces_left"}, nonce_q.size(), 0);
    nonce_q.delete();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_found"}, found, 0);
    check({tag, "_exhausted"}, exhausted, 0);
    check({tag, "_core_start"}, core_start, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c;
    logic seen;
    rst = 1'b0; start = 1'b0; abort = 1'b0; header = '0; target = '0;
    nonce_start = '0; nonce_end = '0; x_load = 1'b0; x_words = '0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_found_nonce", found_nonce, 0);
    check("reset_hash_count", core_hash_count, 0);
    check("reset_blocks", |{core_first_block, core_second_block}, 0);
    rst = 1'b1;

    // Expander alone on the "abc" block.
    @(negedge clk);
    x_words = {32'h61626380, 448'b0, 32'h18};
    x_load  = 1'b1;
    @(negedge clk);
    x_load = 1'b0;
    c = 1;
    while (x_done !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("exp_cycles", c + 1, 48);
    check("exp_w16", x_sched[1535:1504], 32'h61626380);
    check("exp_w17", x_sched[1503:1472], 32'h000f0000);

    // Genesis header, single nonce.
    nonce_q.push_back(32'h7c2bac1d);
    run_job("genesis", GenTgt, 32'h7c2bac1d, 32'h7c2bac1d, 1'b1, 1'b0, 32'h7c2bac1d, 1, 1'b0);
    check("genesis_hash", last_hash, GenHash);
    check("genesis_latency", last_cycles, 48 * 3 + 2 + 1 + 2 * (CoreLat - 1));
    repeat (5) @(negedge clk);
    check("genesis_hold_found", found, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("done_abort_found", found, 0);

    // Range scan with a start pulse while busy.
    for (int i = 0; i < 3; i++) nonce_q.push_back(32'h7c2bac1b + i);
    run_job("scan", GenTgt, 32'h7c2bac1b, 32'h7c2bac1f, 1'b1, 1'b0, 32'h7c2bac1d, 3, 1'b1);

    for (int i = 0; i < 3; i++) nonce_q.push_back(32'h7c2bac1e + i);
    run_job("exhaust", GenTgt, 32'h7c2bac1e, 32'h7c2bac20, 1'b0, 1'b1, 32'h0, 3, 1'b0);

    nonce_q.push_back(32'hffffffff);
    nonce_q.push_back(32'h00000000);
    nonce_q.push_back(32'h00000001);
    run_job("wrap", 256'h0, 32'hffffffff, 32'h00000001, 1'b0, 1'b1, 32'h0, 3, 1'b0);

    // Abort while the core is working on the first hash.
    nonce_q.push_back(32'h7c2bac1d);
    @(negedge clk);
    header = GenHdr; target = GenTgt; nonce_start = 32'h7c2bac1d; nonce_end = 32'h7c2bac1d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (core_start !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("abort_reached_run1", c < 400, 1);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort");
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_start === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    check("abort_quiet", seen, 0);
    nonce_q.push_back(32'h7c2bac1d);
    run_job("post_abort", GenTgt, 32'h7c2bac1d, 32'h7c2bac1d, 1'b1, 1'b0, 32'h7c2bac1d, 1,
            1'b0);

    // Reset while expanding the digest block.
    nonce_q.push_back(32'h7c2bac1d);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 0;
    while (core_start !== 1'b1 && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("rst_reached_run1", c < 400, 1);
    repeat (CoreLat + 10) @(negedge clk);
    check("rst_in_expd_busy", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_mid");
    check("rst_mid_hash_count", core_hash_count, 0);
    check("rst_mid_blocks", |{core_first_block, core_second_block}, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) nonce_q.push_back(32'h7c2bac1b + i);
    run_job("post_rst", GenTgt, 32'h7c2bac1b, 32'h7c2bac1f, 1'b1, 1'b0, 32'h7c2bac1d, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
